// File: rtl/cart_bus_sync.sv
// cart_bus_sync: synchronizes and glitch-filters the cartridge bus for mbc_chip and drives read data back onto it.
module cart_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cart_adr,
  input  logic [7:0]  cart_din,
  input  logic        cart_nrd,
  input  logic        cart_nwr,
  input  logic        cart_ncs,
  input  logic [7:0]  rd_data,
  output logic [15:0] adr,
  output logic [7:0]  data,
  output logic        write,
  output logic        read,
  output logic [7:0]  cart_dout,
  output logic        cart_doe
);
  localparam int CW = $clog2(FILTER + 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][26:0] sync;
  logic [15:0] a_s;
  logic [7:0] d_s, shadow;
  logic nrd_s, nwr_s, ncs_s, nrd_f, nwr_f;
  logic [1:0] str_s, str_f;
  logic [1:0][CW-1:0] cnt;
  assign {a_s, d_s, nrd_s, nwr_s, ncs_s} = sync[SYNC_STAGES-1];
  assign str_s = {nrd_s, nwr_s};
  assign {nrd_f, nwr_f} = str_f;
  // Strobe and /CS stages reset to their idle (high) level so release does not look like an access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= {SYNC_STAGES{27'h7}};
      str_f  <= 2'b11;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      sync[0] <= {cart_adr, cart_din, cart_nrd, cart_nwr, cart_ncs};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      for (int i = 0; i < 2; i++) begin
        if (str_s[i] == str_f[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(FILTER - 1)) begin
          str_f[i] <= str_s[i];
          cnt[i]   <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
      end
      if (!nwr_s) shadow <= d_s;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      adr       <= '0;
      data      <= '0;
      cart_dout <= '0;
      write     <= 1'b0;
      read      <= 1'b0;
      cart_doe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          adr <= a_s;
          if (!nwr_f) begin
            state <= WRITE;
            write <= 1'b1;
          end else if (!nrd_f) begin
            state    <= READ;
            read     <= 1'b1;
            cart_doe <= !a_s[15] || !ncs_s;
          end
        end
        WRITE: begin
          data <= shadow;
          if (nwr_f) begin
            state <= HOLD;
            write <= 1'b0;
          end
        end
        HOLD: state <= IDLE;
        READ: begin
          cart_dout <= rd_data;
          if (nrd_f) begin
            state    <= IDLE;
            read     <= 1'b0;
            cart_doe <= 1'b0;
          end else cart_doe <= !adr[15] || !ncs_s;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cart_bus_sync.sv
// tb_cart_bus_sync: directed checks of write, glitch, data-hold, read, /CS and mid-write reset behaviour.
module tb_cart_bus_sync;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cart_adr;
  logic [7:0]  cart_din, rd_data, data, cart_dout;
  logic        cart_nrd, cart_nwr, cart_ncs;
  logic [15:0] adr;
  logic        write, read, cart_doe;
  int n_chk = 0, n_fail = 0;

  cart_bus_sync dut (
    .clk(clk), .reset_n(reset_n), .cart_adr(cart_adr), .cart_din(cart_din),
    .cart_nrd(cart_nrd), .cart_nwr(cart_nwr), .cart_ncs(cart_ncs), .rd_data(rd_data),
    .adr(adr), .data(data), .write(write), .read(read),
    .cart_dout(cart_dout), .cart_doe(cart_doe)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; cart_adr = '0; cart_din = '0; rd_data = '0;
    cart_nrd = 1'b1; cart_nwr = 1'b1; cart_ncs = 1'b1;
    #1;
    chk("rst_adr", adr, 16'h0000);
    chk("rst_data", {8'h0, data}, 16'h0000);
    chk("rst_dout", {8'h0, cart_dout}, 16'h0000);
    chk("rst_flags", {13'h0, write, read, cart_doe}, 16'h0000);
    step(2);
    reset_n = 1'b1;
    step(1);
    // write 0x05 to 0x2000, /WR low 8 cycles
    cart_adr = 16'h2000; cart_din = 8'h05; cart_nwr = 1'b0;
    step(4);
    chk("wr_before_k4", {15'h0, write}, 16'h0000);
    step(1);
    chk("wr_at_k4", {15'h0, write}, 16'h0001);
    chk("wr_adr", adr, 16'h2000);
    step(3);
    cart_nwr = 1'b1; cart_adr = 16'h1234;
    step(4);
    chk("wr_still_high", {15'h0, write}, 16'h0001);
    step(1);
    chk("wr_fall", {15'h0, write}, 16'h0000);
    chk("hold_adr", adr, 16'h2000);
    chk("hold_data", {8'h0, data}, 16'h0005);
    step(1);
    chk("idle_entry_adr", adr, 16'h2000);
    step(1);
    chk("idle_follow_adr", adr, 16'h1234);
    // one-cycle /WR glitch
    cart_adr = 16'h0000; cart_din = 8'h0A; cart_nwr = 1'b0;
    step(1);
    cart_nwr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_no_write", {15'h0, write}, 16'h0000);
    end
    chk("glitch_data", {8'h0, data}, 16'h0005);
    // data hold: bus data changes on the same edge /WR rises
    cart_din = 8'h0A; cart_nwr = 1'b0;
    step(8);
    cart_nwr = 1'b1; cart_din = 8'hFF;
    step(4);
    chk("dh_write_high", {15'h0, write}, 16'h0001);
    step(1);
    chk("dh_write_fall", {15'h0, write}, 16'h0000);
    chk("dh_data", {8'h0, data}, 16'h000A);
    step(1);
    // ROM read
    cart_adr = 16'h4123; rd_data = 8'h7E; cart_nrd = 1'b0;
    step(4);
    chk("rom_rd_pre", {14'h0, read, cart_doe}, 16'h0000);
    step(1);
    chk("rom_rd_rise", {14'h0, read, cart_doe}, 16'h0003);
    chk("rom_adr", adr, 16'h4123);
    chk("rom_dout_lag", {8'h0, cart_dout}, 16'h0000);
    step(1);
    chk("rom_dout", {8'h0, cart_dout}, 16'h007E);
    step(2);
    cart_nrd = 1'b1;
    step(4);
    chk("rom_rd_hold", {14'h0, read, cart_doe}, 16'h0003);
    step(1);
    chk("rom_rd_fall", {14'h0, read, cart_doe}, 16'h0000);
    chk("rom_dout_keep", {8'h0, cart_dout}, 16'h007E);
    // upper-half read with /CS high
    cart_adr = 16'hA000; cart_nrd = 1'b0; cart_ncs = 1'b1;
    step(5);
    chk("hi_cs1_rd", {14'h0, read, cart_doe}, 16'h0002);
    step(3);
    cart_nrd = 1'b1;
    step(5);
    chk("hi_cs1_end", {14'h0, read, cart_doe}, 16'h0000);
    // upper-half read with /CS low
    cart_ncs = 1'b0; cart_nrd = 1'b0;
    step(5);
    chk("hi_cs0_rd", {14'h0, read, cart_doe}, 16'h0003);
    chk("hi_cs0_adr", adr, 16'hA000);
    step(3);
    cart_nrd = 1'b1; cart_ncs = 1'b1;
    step(3);
    chk("hi_cs_release", {14'h0, read, cart_doe}, 16'h0002);
    step(2);
    chk("hi_cs0_end", {14'h0, read, cart_doe}, 16'h0000);
    // reset pulse mid-write
    cart_adr = 16'h3000; cart_din = 8'h01; cart_nwr = 1'b0;
    step(6);
    chk("rw_write_on", {15'h0, write}, 16'h0001);
    #2;
    reset_n = 1'b0; cart_nwr = 1'b1;
    #1;
    chk("rw_async_flags", {13'h0, write, read, cart_doe}, 16'h0000);
    chk("rw_async_data", {8'h0, data}, 16'h0000);
    #4;
    reset_n = 1'b1;
    step(1);
    chk("rw_no_hold_write", {15'h0, write}, 16'h0000);
    chk("rw_adr_from_reset", adr, 16'h0000);
    step(2);
    chk("rw_adr_follow", adr, 16'h3000);
    chk("rw_idle_write", {15'h0, write}, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
